// File: rtl/ooo_types_pkg.sv
// Shared out-of-order core types: functional-unit encoding, the dispatch uop
// record and the register/ROB widths agreed with the rename stage.
package ooo_types_pkg;

    localparam int PREG_W = 7;
    localparam int ROB_W  = 4;
    localparam int FU_W   = 2;

    typedef enum logic [FU_W-1:0] {
        FU_ALU  = 2'b00,
        FU_LSU  = 2'b01,
        FU_BRU  = 2'b10,
        FU_NONE = 2'b11
    } fu_type_e;

    typedef struct packed {
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] old_prd;
        logic [ROB_W-1:0]  rob_tag;
        fu_type_e          fu_type;
    } dispatch_uop_t;

    // A uop with no execution unit only needs its ROB entry, so it is never held back by an RS.
    function automatic logic fu_sel_ready(input fu_type_e fu, input logic alu_rdy,
                                          input logic lsu_rdy, input logic bru_rdy);
        logic rdy;
        case (fu)
            FU_ALU:  rdy = alu_rdy;
            FU_LSU:  rdy = lsu_rdy;
            FU_BRU:  rdy = bru_rdy;
            default: rdy = 1'b1;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// In-order FIFO of dispatch uops with a flush that discards every entry at the
// next edge; occupancy is exported so the owner derives ready/valid from it.
module dispatch_fifo
    import ooo_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  dispatch_uop_t                data_i,
    input  logic                         pop_i,
    output dispatch_uop_t                data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    dispatch_uop_t      mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               full, empty, push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push_i && !full  && !flush_i;
    assign pop_ok  = pop_i  && !empty && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone says which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dispatch_router.sv
// Dispatch stage: buffers renamed uops and steers the head uop to its RS while writing the ROB.
// Optional feature macro: DISPATCH_STATS_EN adds dispatch/stall statistics counters.
module dispatch_router
    import ooo_types_pkg::*;
#(
    parameter int PREG_WIDTH = PREG_W,
    parameter int ROB_WIDTH  = ROB_W,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [PREG_WIDTH-1:0] in_prs1,
    input  logic [PREG_WIDTH-1:0] in_prs2,
    input  logic [PREG_WIDTH-1:0] in_prd,
    input  logic [PREG_WIDTH-1:0] in_old_prd,
    input  logic [ROB_WIDTH-1:0]  in_rob_tag,
    input  logic [1:0]            in_fu_type,
    output logic                  in_ready,
    output logic                  alu_valid,
    output logic                  lsu_valid,
    output logic                  bru_valid,
    input  logic                  alu_ready,
    input  logic                  lsu_ready,
    input  logic                  bru_ready,
    output logic [PREG_WIDTH-1:0] rs_prs1,
    output logic [PREG_WIDTH-1:0] rs_prs2,
    output logic [PREG_WIDTH-1:0] rs_prd,
    output logic [ROB_WIDTH-1:0]  rs_rob_tag,
    output logic                  rob_wr_en,
    input  logic                  rob_ready,
    output logic [PREG_WIDTH-1:0] rob_prd,
    output logic [PREG_WIDTH-1:0] rob_old_prd,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]           stat_dispatched,
    output logic [31:0]           stat_stall_cycles,
`endif
    input  logic                  branch_mispredict
);

    localparam int CNT_W = $clog2(DEPTH+1);

    dispatch_uop_t      uop_in, head;
    logic [CNT_W-1:0]   count;
    logic               head_valid, enq, sel_ready, issue_ok, dispatch;

    always_comb begin
        uop_in         = '0;
        uop_in.prs1    = in_prs1;
        uop_in.prs2    = in_prs2;
        uop_in.prd     = in_prd;
        uop_in.old_prd = in_old_prd;
        uop_in.rob_tag = in_rob_tag;
        uop_in.fu_type = fu_type_e'(in_fu_type);
    end

    // No full-bypass: ready depends only on stored occupancy, never on this cycle's dequeue.
    assign in_ready   = (count != CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign enq        = in_valid && in_ready && !branch_mispredict;

    dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (branch_mispredict),
        .push_i  (enq),
        .data_i  (uop_in),
        .pop_i   (dispatch),
        .data_o  (head),
        .count_o (count)
    );

    assign sel_ready = fu_sel_ready(head.fu_type, alu_ready, lsu_ready, bru_ready);
    assign issue_ok  = head_valid && rob_ready && !branch_mispredict;
    assign dispatch  = issue_ok && sel_ready;

    // RS valids deliberately ignore the RS's own ready to keep valid/ready loop-free.
    always_comb begin
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        bru_valid   = 1'b0;
        rob_wr_en   = dispatch;
        rs_prs1     = '0;
        rs_prs2     = '0;
        rs_prd      = '0;
        rs_rob_tag  = '0;
        rob_prd     = '0;
        rob_old_prd = '0;
        if (issue_ok) begin
            case (head.fu_type)
                FU_ALU:  alu_valid = 1'b1;
                FU_LSU:  lsu_valid = 1'b1;
                FU_BRU:  bru_valid = 1'b1;
                default: ;
            endcase
        end
        if (head_valid && !branch_mispredict) begin
            rs_prs1     = head.prs1;
            rs_prs2     = head.prs2;
            rs_prd      = head.prd;
            rs_rob_tag  = head.rob_tag;
            rob_prd     = head.prd;
            rob_old_prd = head.old_prd;
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] disp_cnt_q,  disp_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters survive a flush; only reset clears them.
    always_comb begin
        disp_cnt_d  = disp_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (rob_wr_en) disp_cnt_d = disp_cnt_q + 32'd1;
        if (head_valid && !rob_wr_en && !branch_mispredict) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            disp_cnt_q  <= disp_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_dispatched   = disp_cnt_q;
    assign stat_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_router.sv
// Scoreboard bench for dispatch_router: a queue-based reference model predicts each
// cycle's RS/ROB outputs, and a negedge monitor compares what the DUT presents.
module tb_dispatch_router;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [6:0] in_prs1 = '0, in_prs2 = '0, in_prd = '0, in_old_prd = '0;
    logic [3:0] in_rob_tag = '0;
    logic [1:0] in_fu_type = '0;
    logic       in_ready;
    logic       alu_valid, lsu_valid, bru_valid;
    logic       alu_ready = 1'b0, lsu_ready = 1'b0, bru_ready = 1'b0;
    logic [6:0] rs_prs1, rs_prs2, rs_prd, rob_prd, rob_old_prd;
    logic [3:0] rs_rob_tag;
    logic       rob_wr_en;
    logic       rob_ready = 1'b0;
    logic       branch_mispredict = 1'b0;
`ifdef DISPATCH_STATS_EN
    logic [31:0] stat_dispatched, stat_stall_cycles;
    int unsigned m_disp = 0, m_stall = 0;
`endif

    always #5 clk = ~clk;

    dispatch_router #(.PREG_WIDTH(7), .ROB_WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_prs1           (in_prs1),
        .in_prs2           (in_prs2),
        .in_prd            (in_prd),
        .in_old_prd        (in_old_prd),
        .in_rob_tag        (in_rob_tag),
        .in_fu_type        (in_fu_type),
        .in_ready          (in_ready),
        .alu_valid         (alu_valid),
        .lsu_valid         (lsu_valid),
        .bru_valid         (bru_valid),
        .alu_ready         (alu_ready),
        .lsu_ready         (lsu_ready),
        .bru_ready         (bru_ready),
        .rs_prs1           (rs_prs1),
        .rs_prs2           (rs_prs2),
        .rs_prd            (rs_prd),
        .rs_rob_tag        (rs_rob_tag),
        .rob_wr_en         (rob_wr_en),
        .rob_ready         (rob_ready),
        .rob_prd           (rob_prd),
        .rob_old_prd       (rob_old_prd),
`ifdef DISPATCH_STATS_EN
        .stat_dispatched   (stat_dispatched),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .branch_mispredict (branch_mispredict)
    );

    typedef struct {
        logic [6:0] prs1, prs2, prd, old_prd;
        logic [3:0] tag;
        logic [1:0] fu;
    } uop_t;

    typedef struct {
        int         cyc;
        logic       a, l, b, w;
        logic [6:0] prs1, prs2, prd, old_prd;
        logic [3:0] tag;
    } exp_t;

    uop_t mq[$];
    exp_t exp_q[$];
    int   cur_cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cur_cyc, act, req);
        end
    endtask

    // One clock cycle of stimulus; the model reasons about the uop queue directly.
    task automatic step(input logic iv, input logic [1:0] fu, input logic [6:0] prd,
                        input logic [3:0] tag, input logic ar, input logic lr,
                        input logic br, input logic rr, input logic bm);
        uop_t u;
        exp_t e;
        logic hv, rdy, sel, disp;
        u.prs1 = 7'($urandom); u.prs2 = 7'($urandom); u.old_prd = 7'($urandom);
        u.prd = prd; u.tag = tag; u.fu = fu;
        in_valid = iv; in_fu_type = fu; in_prd = prd; in_rob_tag = tag;
        in_prs1 = u.prs1; in_prs2 = u.prs2; in_old_prd = u.old_prd;
        alu_ready = ar; lsu_ready = lr; bru_ready = br; rob_ready = rr;
        branch_mispredict = bm;
        cur_cyc++;
        hv   = (mq.size() != 0);
        rdy  = (mq.size() < DEPTH);
        disp = 1'b0;
        #1;
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        if (hv && rr && !bm) begin
            e.cyc = cur_cyc;
            e.a = (mq[0].fu == 2'd0);
            e.l = (mq[0].fu == 2'd1);
            e.b = (mq[0].fu == 2'd2);
            sel = (mq[0].fu == 2'd0) ? ar : (mq[0].fu == 2'd1) ? lr : (mq[0].fu == 2'd2) ? br : 1'b1;
            e.w = sel;
            e.prs1 = mq[0].prs1; e.prs2 = mq[0].prs2; e.prd = mq[0].prd;
            e.old_prd = mq[0].old_prd; e.tag = mq[0].tag;
            if (e.a || e.l || e.b || e.w) exp_q.push_back(e);
            disp = sel;
        end
`ifdef DISPATCH_STATS_EN
        if (disp) m_disp++;
        if (hv && !disp && !bm) m_stall++;
`endif
        if (bm) mq.delete();
        else begin
            if (disp) void'(mq.pop_front());
            if (iv && rdy) mq.push_back(u);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_valids"}, {28'd0, alu_valid, lsu_valid, bru_valid, rob_wr_en}, 32'd0);
        check({tag, "_payload"}, {4'd0, rs_prs1, rs_prs2, rs_prd, rs_rob_tag}, 32'd0);
`ifdef DISPATCH_STATS_EN
        check({tag, "_stat_disp"}, stat_dispatched, 32'd0);
        check({tag, "_stat_stall"}, stat_stall_cycles, 32'd0);
`endif
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic async_reset();
        in_valid = 1'b0; branch_mispredict = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        mq.delete();
`ifdef DISPATCH_STATS_EN
        m_disp = 0; m_stall = 0;
`endif
        idle_check("async_rst");
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cur_cyc) begin
                e = exp_q.pop_front();
                check("rs_valids", {28'd0, alu_valid, lsu_valid, bru_valid, rob_wr_en},
                      {28'd0, e.a, e.l, e.b, e.w});
                check("rs_payload", {4'd0, rs_prs1, rs_prs2, rs_prd, rs_rob_tag},
                      {4'd0, e.prs1, e.prs2, e.prd, e.tag});
                check("rob_payload", {18'd0, rob_prd, rob_old_prd}, {18'd0, e.prd, e.old_prd});
            end else if (alu_valid || lsu_valid || bru_valid || rob_wr_en) begin
                check("spurious_out", {28'd0, alu_valid, lsu_valid, bru_valid, rob_wr_en}, 32'd0);
            end
        end
    end

    initial begin
        #12;
        idle_check("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Single ALU uop.
        step(1'b0, 2'd0, 7'd0, 4'd0, 1, 1, 1, 1, 0);
        step(1'b1, 2'd0, 7'd5, 4'd3, 1, 1, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0, 4'd0, 1, 1, 1, 1, 0);
        // Steering LSU, BRU, NONE back to back.
        step(1'b1, 2'd1, 7'd10, 4'd4, 1, 1, 1, 1, 0);
        step(1'b1, 2'd2, 7'd11, 4'd5, 1, 1, 1, 1, 0);
        step(1'b1, 2'd3, 7'd0,  4'd6, 1, 1, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 1, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 1, 1, 1, 0);
        // Backpressure then drain in tag order.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 7'(20 + i), 4'(7 + i), 0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 7'd0, 4'd0, 1, 1, 1, 1, 0);
        // Head blocking: LSU stalled in front of a ready ALU uop.
        step(1'b1, 2'd1, 7'd30, 4'd1, 1, 0, 1, 1, 0);
        step(1'b1, 2'd0, 7'd31, 4'd2, 1, 0, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 0, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 1, 1, 1, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 1, 1, 1, 0);
        // Flush a full FIFO.
        step(1'b1, 2'd0, 7'd40, 4'd8, 0, 0, 0, 1, 0);
        step(1'b1, 2'd1, 7'd41, 4'd9, 0, 0, 0, 1, 0);
        step(1'b1, 2'd2, 7'd42, 4'd10, 1, 1, 1, 1, 1);
        step(1'b0, 2'd0, 7'd0,  4'd0, 1, 1, 1, 1, 0);
        // ROB full stalls a ready ALU head.
        step(1'b1, 2'd0, 7'd50, 4'd11, 1, 1, 1, 0, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0,  1, 1, 1, 0, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0,  1, 1, 1, 0, 0);
        step(1'b0, 2'd0, 7'd0,  4'd0,  1, 1, 1, 1, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 65), 2'($urandom), 7'($urandom), 4'($urandom),
                 ($urandom_range(99) < 70), ($urandom_range(99) < 70),
                 ($urandom_range(99) < 70), ($urandom_range(99) < 80),
                 ($urandom_range(99) < 5));
            if (i == 300) begin
                async_reset();
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 7'd0, 4'd0, 1, 1, 1, 1, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef DISPATCH_STATS_EN
        check("stat_dispatched", stat_dispatched, m_disp);
        check("stat_stall_cycles", stat_stall_cycles, m_stall);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
